mux_scan_demux: RTL and testbench
=================================

Name: mux_scan_demux

Overview:
- Scanning receiver for the 4:1 strobed mux (active-low enable G, 2-bit select C, output Y).
- Drives G and C, waits a settle time per channel, samples Y and demultiplexes the four bits back into a registered 4-bit word.
- Presents the word with a one-cycle done pulse.
- Sits beside the mux in the I/O scan path and turns one serial sense line into parallel data for downstream logic.

Parameters:
- SETTLE_CYCLES, 2, cycles G/C are held per channel before Y is sampled; legal range 1..255, elaboration error otherwise.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  input  1  one-cycle request to scan all four channels; honoured only in IDLE.
- abort  input  1  cancels an in-progress scan.
- Y  input  1  mux output; while G=0, Y equals the selected X bit.
- G  output  1  mux enable, active-low.
- C  output  2  mux channel select.
- X_out  output  4  last completed frame; bit i = value of mux input i.
- busy  output  1  high while a scan is in progress (SCAN state).
- done  output  1  one-cycle pulse when X_out has just been updated.

Behaviour:
- One clock: clk. Reset is synchronous and active-low: rst_n, sampled on the rising edge of clk.
- Reset values: G=1, C=2'b00, X_out=4'b0000, busy=0, done=0, state=IDLE, channel index=0, settle counter=0, shadow register=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - G=1, C=0, busy=0.
  - start=1 -> SCAN with ch=0, cnt=0.
- SCAN:
  - G=0, C=ch, busy=1.
  - Each cycle cnt increments.
  - When cnt==SETTLE_CYCLES-1, on that edge: shadow[ch] <= Y and cnt <= 0.
  - If ch==3 -> DONE; else ch <= ch+1 and remain in SCAN.
  - C changes while G stays low; no gap cycle between channels.
- DONE:
  - Single cycle. X_out <= shadow is registered on entry, so X_out and done=1 become visible together.
  - G=1, busy=0 -> IDLE.
- Latency: with start sampled at edge k, done is high in cycle k+4*SETTLE_CYCLES+1.
  - Channel i is driven during cycles k+1+i*S .. k+(i+1)*S, where S=SETTLE_CYCLES.
  - Y is sampled on the edge ending channel i's last cycle.
- X_out holds its value between frames and changes only on the DONE edge.
- start while busy or in DONE: ignored, not queued.
- abort=1 in SCAN:
  - Next state IDLE, G=1, C=0.
  - X_out unchanged, no done pulse, shadow discarded.
- abort=1 in IDLE or DONE: no effect, except abort and start together in IDLE -> abort wins and the block stays in IDLE.
- rst_n=0 mid-scan: all reset values apply at that edge, including clearing X_out; no done pulse.
- Y is treated as synchronous to clk; no synchronizer inside.
- Y is ignored outside the sample edge.
- Channel index is 2 bits, sequence 0..3 only, never wraps.
- Settle counter width is 8 bits.

Decomposition:
- Shared package mux_scan_pkg:
  - state enum {IDLE, SCAN, DONE};
  - NUM_CH=4, SEL_W=2, CNT_W=8;
  - G_ACTIVE=1'b0.
- One natural sub-module, settle_timer: clear/enable inputs, terminal-count output at SETTLE_CYCLES-1, counter width CNT_W.
- The FSM and demux registers stay in the top module.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 cycles, release -> G=1, C=0, X_out=0000, busy=0, done=0 and stable for 10 cycles.
- Basic scan, S=2: mux model with X=4'b1010, pulse start at edge 0 -> C sequence 0,0,1,1,2,2,3,3 with G=0 over cycles 1..8; done=1 and X_out=1010 in cycle 9; G=1 in cycle 10.
- Back-to-back frames: X=0110 then X=1001, start re-pulsed the cycle after done -> second done 9 cycles later with X_out=1001; X_out=0110 held in between.
- start while busy: extra start pulses at cycles 3 and 5 of a scan -> exactly one done pulse, no second scan.
- Abort mid-scan: X_out=0011 from a prior frame, abort at cycle 4 -> G=1 and busy=0 next cycle, no done, X_out stays 0011; a start/abort collision in IDLE -> no scan starts.
- Reset mid-scan and S=1: rst_n=0 at cycle 3 -> reset values next cycle. Then with SETTLE_CYCLES=1 and X=1111 -> done at cycle 5 with X_out=1111.

Source files
------------

// File: rtl/mux_scan_demux_pkg.sv
// Shared types and widths for the mux scan receiver.
package mux_scan_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

    localparam int   NUM_CH   = 4;
    localparam int   SEL_W    = 2;
    localparam int   CNT_W    = 8;
    localparam logic G_ACTIVE = 1'b0;
endpackage

// File: rtl/mux_scan_demux_if.sv
// Scan-side bus: request/abort in, mux control out, sensed Y in, frame out.
interface mux_scan_demux_if;
    import mux_scan_pkg::*;

    logic              start;
    logic              abort;
    logic              Y;
    logic              G;
    logic [SEL_W-1:0]  C;
    logic [NUM_CH-1:0] X_out;
    logic              busy;
    logic              done;

    modport master (input start, abort, Y, output G, C, X_out, busy, done);
    modport slave  (output start, abort, Y, input G, C, X_out, busy, done);
endinterface

// File: rtl/mux_scan_demux_settle_timer.sv
// Per-channel settle counter; tc marks the last settle cycle of a channel.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int TMR_W         = CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [TMR_W-1:0] cnt;

    assign tc = (cnt == TMR_W'(SETTLE_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + TMR_W'(1);
    end
endmodule

// File: rtl/mux_scan_demux.sv
// Scans the four mux channels through G/C, samples Y per channel and
// presents the assembled word on X_out with a one-cycle done pulse.
module mux_scan_demux
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_scan_demux_if.master  bus
);
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("mux_scan_demux: SETTLE_CYCLES must be in 1..255");
    end

    state_e            state, state_nxt;
    logic [SEL_W-1:0]  ch;
    logic [NUM_CH-1:0] shadow, frame, x_q;
    logic              tc, last_ch, sample;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TMR_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state != SCAN || bus.abort),
        .en    (state == SCAN),
        .tc    (tc)
    );

    assign last_ch   = (ch == SEL_W'(NUM_CH - 1));
    assign sample    = (state == SCAN) && !bus.abort && tc;
    assign bus.X_out = x_q;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus.G     = ~G_ACTIVE;
        bus.C     = '0;
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        case (state)
            IDLE: if (bus.start && !bus.abort) state_nxt = SCAN;
            SCAN: begin
                bus.G    = G_ACTIVE;
                bus.C    = ch;
                bus.busy = 1'b1;
                if (bus.abort)
                    state_nxt = IDLE;
                else if (tc && last_ch)
                    state_nxt = DONE;
            end
            DONE: begin
                bus.done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Merge the bit being sampled now so the final channel lands in X_out on the same edge.
    always_comb begin
        frame     = shadow;
        frame[ch] = bus.Y;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch     <= '0;
            shadow <= '0;
            x_q    <= '0;
        end else if (sample) begin
            shadow <= frame;
            if (last_ch)
                x_q <= frame;
            else
                ch <= ch + SEL_W'(1);
        end else if (state != SCAN) begin
            ch <= '0;
        end
    end
endmodule

// File: tb/tb_mux_scan_demux.sv
// Randomized frame-level check of two scanners (settle 2 and settle 1) against a mux model.
module tb_mux_scan_demux;
    import mux_scan_pkg::*;

    logic       clk = 1'b0;
    logic       rst0, rst1;
    logic [3:0] x0, x1;
    logic       n0, n1;
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [3:0] prev [2];
    int         S [2] = '{2, 1};

    always #5 clk = ~clk;

    mux_scan_demux_if b0 ();
    mux_scan_demux_if b1 ();

    mux_scan_demux #(.SETTLE_CYCLES(2)) u0 (.clk(clk), .rst_n(rst0), .bus(b0));
    mux_scan_demux #(.SETTLE_CYCLES(1)) u1 (.clk(clk), .rst_n(rst1), .bus(b1));

    // Mux model: enabled -> selected input bit, disabled -> noise.
    assign b0.Y = (b0.G == G_ACTIVE) ? x0[b0.C] : n0;
    assign b1.Y = (b1.G == G_ACTIVE) ? x1[b1.C] : n1;

    always @(negedge clk) begin
        n0 = 1'($urandom);
        n1 = 1'($urandom);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int w, input logic st, input logic ab, input logic rs);
        if (w == 0) begin b0.start = st; b0.abort = ab; rst0 = rs; end
        else        begin b1.start = st; b1.abort = ab; rst1 = rs; end
    endtask

    task automatic chk_state(input int w, input string tag, input logic g, input logic [1:0] c,
                             input logic bz, input logic dn, input logic [3:0] xo);
        logic       og, obz, odn;
        logic [1:0] oc;
        logic [3:0] oxo;
        if (w == 0) begin og = b0.G; oc = b0.C; obz = b0.busy; odn = b0.done; oxo = b0.X_out; end
        else        begin og = b1.G; oc = b1.C; obz = b1.busy; odn = b1.done; oxo = b1.X_out; end
        chk($sformatf("u%0d.%s.G", w, tag),     32'(og),  32'(g));
        chk($sformatf("u%0d.%s.C", w, tag),     32'(oc),  32'(c));
        chk($sformatf("u%0d.%s.busy", w, tag),  32'(obz), 32'(bz));
        chk($sformatf("u%0d.%s.done", w, tag),  32'(odn), 32'(dn));
        chk($sformatf("u%0d.%s.X_out", w, tag), 32'(oxo), 32'(xo));
    endtask

    // Idle cycles with stray aborts, which must have no effect.
    task automatic idle(input int w, input int n);
        for (int i = 0; i < n; i++) begin
            chk_state(w, "idle", 1'b1, 2'd0, 1'b0, 1'b0, prev[w]);
            drive(w, 1'b0, 1'($urandom), 1'b1);
            step();
            drive(w, 1'b0, 1'b0, 1'b1);
        end
    endtask

    // One scan request; abort_at/rst_at pick the scan cycle of an interruption (0 = none),
    // extra marks scan cycles carrying a redundant start.
    task automatic frame(input int w, input logic [3:0] x, input int abort_at, input int rst_at,
                         input logic [31:0] extra, input logic start_in_done);
        if (w == 0) x0 = x; else x1 = x;
        drive(w, 1'b1, 1'b0, 1'b1);
        step();
        drive(w, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 4 * S[w]; t++) begin
            chk_state(w, "scan", 1'b0, 2'((t - 1) / S[w]), 1'b1, 1'b0, prev[w]);
            if (t == abort_at) begin
                drive(w, 1'b0, 1'b1, 1'b1);
                step();
                drive(w, 1'b0, 1'b0, 1'b1);
                chk_state(w, "abort", 1'b1, 2'd0, 1'b0, 1'b0, prev[w]);
                return;
            end
            if (t == rst_at) begin
                drive(w, 1'b0, 1'b0, 1'b0);
                step();
                drive(w, 1'b0, 1'b0, 1'b1);
                prev[w] = 4'b0000;
                chk_state(w, "rst", 1'b1, 2'd0, 1'b0, 1'b0, prev[w]);
                return;
            end
            drive(w, extra[t], 1'b0, 1'b1);
            step();
            drive(w, 1'b0, 1'b0, 1'b1);
        end
        chk_state(w, "done", 1'b1, 2'd0, 1'b0, 1'b1, x);
        prev[w] = x;
        drive(w, start_in_done, 1'b0, 1'b1);
        step();
        drive(w, 1'b0, 1'b0, 1'b1);
        chk_state(w, "post", 1'b1, 2'd0, 1'b0, 1'b0, x);
    endtask

    initial begin
        int r;
        prev[0] = 4'b0000;
        prev[1] = 4'b0000;
        x0 = 4'b0000;
        x1 = 4'b0000;
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        step();
        step();
        drive(0, 1'b0, 1'b0, 1'b1);
        drive(1, 1'b0, 1'b0, 1'b1);
        idle(0, 10);
        idle(1, 3);

        // Directed frames with settle 2.
        frame(0, 4'b1010, 0, 0, 32'h0, 1'b0);
        frame(0, 4'b0110, 0, 0, 32'h0, 1'b0);
        frame(0, 4'b1001, 0, 0, 32'h0, 1'b1);
        frame(0, 4'b0101, 0, 0, (32'h1 << 3) | (32'h1 << 5), 1'b0);
        idle(0, 4);
        frame(0, 4'b0011, 0, 0, 32'h0, 1'b0);
        frame(0, 4'b1100, 4, 0, 32'h0, 1'b0);
        idle(0, 2);
        drive(0, 1'b1, 1'b1, 1'b1);
        step();
        drive(0, 1'b0, 1'b0, 1'b1);
        idle(0, 3);
        frame(0, 4'b1110, 0, 3, 32'h0, 1'b0);
        idle(0, 2);

        // Settle 1.
        frame(1, 4'b1111, 0, 0, 32'h0, 1'b0);
        frame(1, 4'b0100, 0, 0, 32'h0, 1'b0);

        // Randomized phase on both scanners.
        for (int w = 0; w < 2; w++) begin
            for (int i = 0; i < 40; i++) begin
                r = int'($urandom_range(0, 9));
                if (r == 0)
                    frame(w, 4'($urandom), int'($urandom_range(1, 4 * S[w])), 0, 32'h0, 1'b0);
                else if (r == 1)
                    frame(w, 4'($urandom), 0, int'($urandom_range(1, 4 * S[w])), 32'h0, 1'b0);
                else if (r == 2) begin
                    drive(w, 1'b1, 1'b1, 1'b1);
                    step();
                    drive(w, 1'b0, 1'b0, 1'b1);
                end else
                    frame(w, 4'($urandom), 0, 0, $urandom & 32'h1fe, 1'($urandom));
                idle(w, int'($urandom_range(0, 3)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
